// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and mode constants for the period timer
package timer_pkg;
    typedef enum logic {IDLE, RUN} tmr_state_t;
    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;
endpackage

// File: rtl/timer_channel.sv
// timer_channel: one period timer with shadowed reload and sticky pending/overrun
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = 21
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic             stop_in,
    input  logic             mode_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] period_in,
    input  logic             ack_in,
    output logic [WIDTH-1:0] count_out,
    output logic             tick_out,
    output logic             busy_out,
    output logic             pending_out,
    output logic             overrun_out
);
    tmr_state_t       state, state_n;
    logic [WIDTH-1:0] active, active_n, shadow, count_n, eff;
    logic             mode, mode_n, tick_n, go, term, periodic;

    always_comb begin
        eff      = load_in ? period_in : shadow;
        go       = start_in && eff != '0;
        term     = state == RUN && count_out == active - WIDTH'(1);
        periodic = mode == MODE_PERIODIC;
        state_n  = state;
        count_n  = count_out;
        active_n = active;
        mode_n   = mode;
        tick_n   = 1'b0;
        if (stop_in) begin
            state_n = IDLE;
            count_n = '0;
        end else if (go) begin
            state_n  = RUN;
            count_n  = '0;
            active_n = eff;
            mode_n   = mode_in;
        end else if (term) begin
            // a zero reload still emits this tick, then parks the channel
            tick_n   = 1'b1;
            count_n  = '0;
            active_n = periodic ? eff : active;
            state_n  = (periodic && eff != '0) ? RUN : IDLE;
        end else if (state == RUN) begin
            count_n = count_out + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= IDLE;
            count_out   <= '0;
            active      <= '0;
            shadow      <= '0;
            mode        <= MODE_ONESHOT;
            tick_out    <= 1'b0;
            pending_out <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            state       <= state_n;
            count_out   <= count_n;
            active      <= active_n;
            shadow      <= load_in ? period_in : shadow;
            mode        <= mode_n;
            tick_out    <= tick_n;
            pending_out <= tick_n | (pending_out & ~ack_in);
            overrun_out <= overrun_out | (tick_n & pending_out & ~ack_in);
        end
    end

    assign busy_out = state == RUN;
endmodule

// File: rtl/multi_period_timer.sv
// multi_period_timer: NUM_CH independent period timers sharing one clock
module multi_period_timer
    import timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 21
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [NUM_CH-1:0]       start_in,
    input  logic [NUM_CH-1:0]       stop_in,
    input  logic [NUM_CH-1:0]       mode_in,
    input  logic [NUM_CH-1:0]       load_in,
    input  logic [NUM_CH*WIDTH-1:0] period_in,
    input  logic [NUM_CH-1:0]       ack_in,
    output logic [NUM_CH*WIDTH-1:0] count_out,
    output logic [NUM_CH-1:0]       tick_out,
    output logic [NUM_CH-1:0]       busy_out,
    output logic [NUM_CH-1:0]       pending_out,
    output logic [NUM_CH-1:0]       overrun_out
);
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_channel #(.WIDTH(WIDTH)) u_ch (
            .clk_in     (clk_in),
            .rst_in     (rst_in),
            .start_in   (start_in[i]),
            .stop_in    (stop_in[i]),
            .mode_in    (mode_in[i]),
            .load_in    (load_in[i]),
            .period_in  (period_in[i*WIDTH +: WIDTH]),
            .ack_in     (ack_in[i]),
            .count_out  (count_out[i*WIDTH +: WIDTH]),
            .tick_out   (tick_out[i]),
            .busy_out   (busy_out[i]),
            .pending_out(pending_out[i]),
            .overrun_out(overrun_out[i])
        );
    end
endmodule

// File: tb/tb_multi_period_timer.sv
// tb_multi_period_timer: vector table, directed corner cases and random run against a reference model
module tb_multi_period_timer;
    localparam int N = 4;
    localparam int W = 21;

    logic           clk_in = 1'b0;
    logic           rst_in;
    logic [N-1:0]   start_in, stop_in, mode_in, load_in, ack_in;
    logic [N*W-1:0] period_in;
    logic [N*W-1:0] count_out;
    logic [N-1:0]   tick_out, busy_out, pending_out, overrun_out;

    multi_period_timer #(.NUM_CH(N), .WIDTH(W)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .start_in   (start_in),
        .stop_in    (stop_in),
        .mode_in    (mode_in),
        .load_in    (load_in),
        .period_in  (period_in),
        .ack_in     (ack_in),
        .count_out  (count_out),
        .tick_out   (tick_out),
        .busy_out   (busy_out),
        .pending_out(pending_out),
        .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;

    // reference: each running channel holds cycles-left-until-tick; count is period minus that
    bit m_run[N], m_md[N], m_pend[N], m_ovr[N], m_tk[N];
    int m_per[N], m_left[N], m_sh[N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic model_update();
        for (int c = 0; c < N; c++) begin
            int eff;
            eff = load_in[c] ? int'(period_in[c*W +: W]) : m_sh[c];
            m_tk[c] = 1'b0;
            if (rst_in) begin
                m_run[c] = 0; m_md[c] = 0; m_pend[c] = 0; m_ovr[c] = 0;
                m_per[c] = 0; m_left[c] = 0; m_sh[c] = 0;
                continue;
            end
            if (stop_in[c]) m_run[c] = 1'b0;
            else if (start_in[c] && eff != 0) begin
                m_run[c] = 1'b1; m_per[c] = eff; m_left[c] = eff; m_md[c] = mode_in[c];
            end else if (m_run[c]) begin
                m_left[c]--;
                if (m_left[c] == 0) begin
                    m_tk[c] = 1'b1;
                    if (m_md[c]) begin
                        m_per[c] = eff; m_left[c] = eff; m_run[c] = eff != 0;
                    end else m_run[c] = 1'b0;
                end
            end
            if (load_in[c]) m_sh[c] = int'(period_in[c*W +: W]);
            if (m_tk[c] && m_pend[c] && !ack_in[c]) m_ovr[c] = 1'b1;
            m_pend[c] = m_tk[c] ? 1'b1 : (ack_in[c] ? 1'b0 : m_pend[c]);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        model_update();
        #1;
        for (int c = 0; c < N; c++) begin
            chk($sformatf("m_count[%0d]", c), 64'(count_out[c*W +: W]),
                m_run[c] ? 64'(m_per[c] - m_left[c]) : 64'd0);
            chk($sformatf("m_tick[%0d]", c), 64'(tick_out[c]), 64'(m_tk[c]));
            chk($sformatf("m_busy[%0d]", c), 64'(busy_out[c]), 64'(m_run[c]));
            chk($sformatf("m_pend[%0d]", c), 64'(pending_out[c]), 64'(m_pend[c]));
            chk($sformatf("m_ovr[%0d]", c), 64'(overrun_out[c]), 64'(m_ovr[c]));
        end
    endtask

    task automatic quiet();
        start_in = '0; stop_in = '0; load_in = '0; ack_in = '0;
    endtask

    task automatic launch(input int c, input int p, input bit md);
        start_in[c] = 1'b1; load_in[c] = 1'b1; mode_in[c] = md;
        period_in[c*W +: W] = W'(p);
    endtask

    typedef struct {
        logic         st;
        logic         ld;
        logic [W-1:0] per;
        logic [W-1:0] cnt;
        logic         tk;
        logic         bz;
    } vec_t;
    vec_t tbl[10];

    initial begin
        int first_all;
        tbl[0] = '{1'b1, 1'b1, W'(3), W'(0), 1'b0, 1'b1};
        for (int i = 1; i < 10; i++) tbl[i] = '{1'b0, 1'b0, '0, W'(i % 3), i % 3 == 0, 1'b1};
        rst_in = 1'b1; quiet(); mode_in = '0; period_in = '0;
        step(); step();
        chk("rst_count", 64'(count_out), 64'd0);
        chk("rst_tick", 64'(tick_out), 64'd0);
        chk("rst_busy", 64'(busy_out), 64'd0);
        chk("rst_pend", 64'(pending_out), 64'd0);
        chk("rst_ovr", 64'(overrun_out), 64'd0);
        rst_in = 1'b0;

        // periodic P=3 on ch0
        for (int i = 0; i < 10; i++) begin
            start_in[0] = tbl[i].st; load_in[0] = tbl[i].ld; mode_in[0] = 1'b1;
            period_in[W-1:0] = tbl[i].per;
            step();
            chk($sformatf("tbl_cnt[%0d]", i), 64'(count_out[W-1:0]), 64'(tbl[i].cnt));
            chk($sformatf("tbl_tick[%0d]", i), 64'(tick_out[0]), 64'(tbl[i].tk));
            chk($sformatf("tbl_busy[%0d]", i), 64'(busy_out[0]), 64'(tbl[i].bz));
            quiet();
        end
        stop_in[0] = 1'b1; step(); quiet();

        // one-shot P=5 on ch1
        launch(1, 5, 1'b0); step(); quiet();
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("os_tick[%0d]", k), 64'(tick_out[1]), 64'(k == 5));
            chk($sformatf("os_busy[%0d]", k), 64'(busy_out[1]), 64'(k < 5));
            if (k >= 5) chk($sformatf("os_cnt[%0d]", k), 64'(count_out[W +: W]), 64'd0);
        end

        // reload on ch2: P=4, load 2 mid-period, load 7 at a terminal edge
        launch(2, 4, 1'b1); step(); quiet();
        for (int k = 1; k <= 16; k++) begin
            load_in[2] = k == 2 || k == 8;
            period_in[2*W +: W] = k == 2 ? W'(2) : W'(7);
            step();
            chk($sformatf("rl_tick[%0d]", k), 64'(tick_out[2]), 64'(k == 4 || k == 6 || k == 8 || k == 15));
        end
        quiet(); stop_in[2] = 1'b1; step(); quiet();

        // P=1 with no ack: tick every cycle and overrun
        launch(0, 1, 1'b1); step(); quiet();
        step(); step();
        chk("p1_tick", 64'(tick_out[0]), 64'd1);
        chk("p1_cnt", 64'(count_out[W-1:0]), 64'd0);
        chk("p1_pend", 64'(pending_out[0]), 64'd1);
        chk("p1_ovr", 64'(overrun_out[0]), 64'd1);

        // start+stop same cycle, then stop mid-period (ch1 shadow is 5)
        start_in[1] = 1'b1; stop_in[1] = 1'b1; mode_in[1] = 1'b1; step(); quiet();
        chk("ss_busy", 64'(busy_out[1]), 64'd0);
        start_in[1] = 1'b1; step(); quiet(); step(); step();
        stop_in[1] = 1'b1; step(); quiet();
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("stop_tick[%0d]", k), 64'(tick_out[1]), 64'd0);
        end
        chk("stop_busy", 64'(busy_out[1]), 64'd0);

        // reset mid-run on all channels, then a start with a cleared shadow
        for (int c = 0; c < N; c++) launch(c, c + 2, 1'b1);
        step(); quiet(); step(); step();
        rst_in = 1'b1; step(); rst_in = 1'b0;
        chk("rr_count", 64'(count_out), 64'd0);
        chk("rr_tick", 64'(tick_out), 64'd0);
        chk("rr_busy", 64'(busy_out), 64'd0);
        chk("rr_pend", 64'(pending_out), 64'd0);
        chk("rr_ovr", 64'(overrun_out), 64'd0);
        start_in[0] = 1'b1; step(); quiet();
        chk("zero_shadow_busy", 64'(busy_out[0]), 64'd0);

        // ack handshake on ch3, P=2
        launch(3, 2, 1'b1); step(); quiet();
        step(); step();
        chk("ack_pend1", 64'(pending_out[3]), 64'd1);
        step(); ack_in[3] = 1'b1; step();
        chk("ack_tick", 64'(tick_out[3]), 64'd1);
        chk("ack_pend2", 64'(pending_out[3]), 64'd1);
        chk("ack_ovr2", 64'(overrun_out[3]), 64'd0);
        step(); quiet();
        chk("ack_pend3", 64'(pending_out[3]), 64'd0);
        chk("ack_ovr3", 64'(overrun_out[3]), 64'd0);

        // periods 2/3/5/7 first coincide at cycle 210
        launch(0, 2, 1'b1); launch(1, 3, 1'b1); launch(2, 5, 1'b1); launch(3, 7, 1'b1);
        step(); quiet();
        first_all = -1;
        for (int k = 1; k <= 210; k++) begin
            step();
            if (tick_out == 4'hF && first_all < 0) first_all = k;
        end
        chk("coincide", 64'(first_all), 64'd210);

        // randomized traffic against the model
        rst_in = 1'b1; step(); rst_in = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < N; c++) begin
                start_in[c] = $urandom_range(0, 15) == 0;
                stop_in[c]  = $urandom_range(0, 31) == 0;
                load_in[c]  = $urandom_range(0, 7) == 0;
                ack_in[c]   = $urandom_range(0, 3) == 0;
                mode_in[c]  = 1'($urandom_range(0, 1));
                period_in[c*W +: W] = W'($urandom_range(0, 6));
            end
            step();
        end
        quiet();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multi_period_timer.md
Name: multi_period_timer

Overview:
Parametrised multi-channel period timer, successor to the single-channel free-running period counter. Each channel has the following features:
- Periodic or one-shot mode.
- Start/stop control.
- Shadowed period reload applied only at period boundaries.
- A sticky pending flag with ack handshake and overrun detection.

It drives frame-rate, sampling and PWM-style event timing for the motion-sensing pipeline.

Parameters:
- NUM_CH, 4, number of independent timer channels (1..16).
- WIDTH, 21, bit width of period and count per channel.

Ports:
- clk_in, input, 1, system clock.
- rst_in, input, 1, synchronous active-high reset.
- start_in, input, NUM_CH, per-channel start pulse; restarts the count from 0.
- stop_in, input, NUM_CH, per-channel stop pulse; returns the channel to IDLE.
- mode_in, input, NUM_CH, per channel: 1 = periodic, 0 = one-shot. Sampled on start.
- load_in, input, NUM_CH, per-channel strobe that captures period_in into the shadow register.
- period_in, input, NUM_CH x WIDTH, packed new period values in cycles.
- ack_in, input, NUM_CH, clears pending_out.
- count_out, output, NUM_CH x WIDTH, current count per channel.
- tick_out, output, NUM_CH, one-cycle pulse at each period boundary.
- busy_out, output, NUM_CH, 1 while the channel is in RUN.
- pending_out, output, NUM_CH, sticky: set by tick, cleared by ack.
- overrun_out, output, NUM_CH, sticky: tick occurred while pending was set; cleared only by reset.

Behaviour:
- Clock and reset: single clock domain, clk_in. rst_in is synchronous and active-high.
- Reset values:
  - Outputs: all outputs 0.
  - Per-channel registers: state IDLE; shadow and active period 0; mode latch 0.
- Channels are fully independent; no cross-channel interaction.
- Per-channel FSM (IDLE, RUN):
  - IDLE -> RUN on start_in when the effective period is nonzero. The effective period is period_in if load_in is high in the same cycle, otherwise the shadow.
  - At that edge: count <= 0, active period <= effective period, mode latch <= mode_in.
  - Start with an effective period of 0: ignored, channel stays in IDLE.
  - RUN -> IDLE on stop_in (count <= 0, no tick), or at the terminal edge in one-shot mode.
  - start_in while in RUN: restart. count <= 0, active period and mode reloaded, no tick.
  - stop_in and start_in in the same cycle: stop wins.
- Counting in RUN:
  - Each edge: if count == active-1, then count <= 0 and tick <= 1 (terminal edge); else count <= count+1 and tick <= 0.
  - The terminal compare is done at WIDTH bits. No wider arithmetic; count never exceeds active-1.
  - With period P, tick_out is high for exactly 1 cycle every P cycles. The first tick is P edges after the start edge.
  - P = 1: tick_out high every cycle, count_out stays 0.
  - Max period is 2^WIDTH-1.
- Shadow reload:
  - load_in writes the shadow at the edge. Active period is unchanged mid-period.
  - At a terminal edge in periodic mode: active <= shadow, or period_in if load_in is high in the same cycle.
  - If the new value is 0: the channel goes to IDLE after this tick. The tick is still emitted.
- Mode latch: mode_in changes during RUN have no effect until the next start.
- pending/overrun:
  - On tick: pending <= 1. If pending was already 1 and ack_in is 0, overrun <= 1.
  - ack_in with no tick in the same cycle: pending <= 0.
  - ack_in and tick in the same cycle: pending stays 1, no overrun (ack retires the old event).
- In IDLE: count_out = 0, tick_out = 0, busy_out = 0.
- Reset mid-run: all channels return to IDLE next edge; shadows are cleared.
- Latency: all outputs are registered. Control inputs take effect on the edge they are sampled.

Decomposition:
- Shared package timer_pkg:
  - typedef enum logic {IDLE, RUN} tmr_state_t.
  - Constants MODE_ONESHOT = 1'b0 and MODE_PERIODIC = 1'b1.
- Sub-module timer_channel (parameter WIDTH): one FSM, counter, shadow, and pending/overrun logic.
- multi_period_timer is a generate loop of NUM_CH timer_channel instances with packed-array slicing.

Test Plan:
- Periodic P=3 on ch0, start at cycle 0: count_out sequence 0,1,2,0,1,2; tick_out high at cycles 3, 6, 9; busy_out = 1 throughout.
- One-shot P=5 on ch1: single tick at cycle 5; busy_out drops the same edge; count_out = 0 afterwards; no further ticks.
- Reload while running with P=4 and load 2 at cycle 2: next tick at cycle 4, then at cycles 6 and 8. load_in at the terminal edge with 7: the next period is 7.
- Pending/overrun: two ticks with no ack -> pending = 1, overrun = 1. Ack coincident with a tick -> pending stays 1, overrun stays 0. Ack alone -> pending = 0.
- Edge cases:
  - start with shadow 0 -> channel stays IDLE.
  - P = 1 -> tick every cycle.
  - start+stop in the same cycle -> IDLE.
  - stop mid-period -> no tick.
  - NUM_CH = 4 independent periods 2/3/5/7 -> ticks coincide at cycle 210.
- Reset mid-run on all channels -> the next cycle shows all outputs 0; after reset a start with no load is ignored because the shadow was cleared.
